fw_cmd_decoder: RTL and testbench

//  Host-side responder for 32-bit command words {device_id[31:28], op_code[27:24], body[23:0]}.

---
 rtl/fw_cmd_decoder_pkg.sv | 96 +++++++++
 rtl/fw_cmd_decoder_if.sv | 14 +
 rtl/fw_cmd_array_ptr.sv | 43 ++++
 rtl/fw_cmd_decoder.sv | 151 +++++++++++++++
 tb/tb_fw_cmd_decoder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/fw_cmd_decoder_pkg.sv
// rtl/fw_cmd_decoder_pkg.sv - shared types, field positions and decode helpers for fw_cmd_decoder
package fw_cmd_decoder_pkg;

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, RSP} state_t_fw_cmd_decoder;

  typedef enum logic [3:0] {
    OP_NOOP              = 4'h0,
    OP_W_RST_FW          = 4'h1,
    OP_W_CFG_STATIC_0    = 4'h2,
    OP_R_CFG_STATIC_0    = 4'h3,
    OP_W_CFG_STATIC_1    = 4'h4,
    OP_R_CFG_STATIC_1    = 4'h5,
    OP_W_CFG_ARRAY_0     = 4'h6,
    OP_R_CFG_ARRAY_0     = 4'h7,
    OP_W_CFG_ARRAY_1     = 4'h8,
    OP_R_CFG_ARRAY_1     = 4'h9,
    OP_W_CFG_ARRAY_2     = 4'hA,
    OP_R_CFG_ARRAY_2     = 4'hB,
    OP_R_DATA_ARRAY_0    = 4'hC,
    OP_R_DATA_ARRAY_1    = 4'hD,
    OP_W_STATUS_FW_CLEAR = 4'hE,
    OP_W_EXECUTE         = 4'hF
  } op_code_t;

  localparam int cfg_array_words  = 217;
  localparam int data_array_words = 32;

  localparam int windex_device_id = 28;
  localparam int windex_op_code   = 24;
  localparam int windex_body      = 0;
  localparam int rindex_device_id = 28;
  localparam int rindex_op_code   = 24;
  localparam int rindex_data      = 0;

  localparam int status_index_rst_fw    = 0;
  localparam int status_index_execute   = 13;
  localparam int status_index_test_done = 14;
  localparam int status_index_exec_err  = 31;

  typedef struct packed {
    logic [23:0] cfg_static_0;
    logic [23:0] cfg_static_1;
    logic [23:0] exec_cfg;
    logic        exec_start;
    logic        fw_soft_rst;
    logic        arr_wr_en;
    logic [2:0]  arr_sel;
    logic [7:0]  arr_addr;
    logic [23:0] arr_wdata;
    logic [31:0] rsp_word;
    logic [31:0] status;
  } dec_regs_t;

  // Ops 1..13 own status bits 0..12 in op order; execute owns bit 13, clear owns none.
  function automatic logic [31:0] status_set_mask(input op_code_t op);
    case (op)
      OP_NOOP, OP_W_STATUS_FW_CLEAR: return 32'h0;
      OP_W_EXECUTE:                  return 32'h1 << status_index_execute;
      default:                       return 32'h1 << (op - 4'd1);
    endcase
  endfunction

  function automatic logic is_wr_array(input op_code_t op);
    return op inside {OP_W_CFG_ARRAY_0, OP_W_CFG_ARRAY_1, OP_W_CFG_ARRAY_2};
  endfunction

  function automatic logic is_rd_array(input op_code_t op);
    return op inside {OP_R_CFG_ARRAY_0, OP_R_CFG_ARRAY_1, OP_R_CFG_ARRAY_2,
                      OP_R_DATA_ARRAY_0, OP_R_DATA_ARRAY_1};
  endfunction

  function automatic logic [2:0] arr_index(input op_code_t op);
    case (op)
      OP_W_CFG_ARRAY_1, OP_R_CFG_ARRAY_1: return 3'd1;
      OP_W_CFG_ARRAY_2, OP_R_CFG_ARRAY_2: return 3'd2;
      OP_R_DATA_ARRAY_0:                  return 3'd3;
      OP_R_DATA_ARRAY_1:                  return 3'd4;
      default:                            return 3'd0;
    endcase
  endfunction

  function automatic logic onehot4(input logic [3:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic logic [31:0] pack_rsp(input logic [3:0] id, input op_code_t op,
                                           input logic [23:0] data);
    logic [31:0] w;
    w = '0;
    w[rindex_device_id +: 4] = id;
    w[rindex_op_code +: 4]   = op;
    w[rindex_data +: 24]     = data;
    return w;
  endfunction

endpackage

// File: rtl/fw_cmd_decoder_if.sv
// rtl/fw_cmd_decoder_if.sv - host command/response channel bundle for fw_cmd_decoder
interface fw_cmd_decoder_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_word;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_word;

  modport master (output cmd_valid, cmd_word, rsp_ready,
                  input  cmd_ready, rsp_valid, rsp_word);
  modport slave  (input  cmd_valid, cmd_word, rsp_ready,
                  output cmd_ready, rsp_valid, rsp_word);
endinterface

// File: rtl/fw_cmd_array_ptr.sv
// rtl/fw_cmd_array_ptr.sv - five wrap-around word pointers (cfg_array_0..2, data_array_0..1)
module fw_cmd_array_ptr
  import fw_cmd_decoder_pkg::*;
#(
  parameter int CFG_WORDS  = cfg_array_words,
  parameter int DATA_WORDS = data_array_words
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc,
  input  logic [2:0] sel,
  output logic [7:0] ptr
);
  localparam int         NUM_ARRAYS = 5;
  localparam logic [7:0] CFG_LAST   = 8'(CFG_WORDS - 1);
  localparam logic [7:0] DATA_LAST  = 8'(DATA_WORDS - 1);

  logic [7:0] ptr_q [NUM_ARRAYS];
  logic [7:0] ptr_d [NUM_ARRAYS];

  always_comb begin
    ptr = '0;
    for (int i = 0; i < NUM_ARRAYS; i++) begin
      ptr_d[i] = ptr_q[i];
      if (sel == 3'(i)) begin
        ptr = ptr_q[i];
        if (inc) begin
          ptr_d[i] = (ptr_q[i] == ((i < 3) ? CFG_LAST : DATA_LAST)) ? 8'd0 : ptr_q[i] + 8'd1;
        end
      end
      if (clear) ptr_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ARRAYS; i++) begin
      if (rst) ptr_q[i] <= '0;
      else     ptr_q[i] <= ptr_d[i];
    end
  end

endmodule

// File: rtl/fw_cmd_decoder.sv
// rtl/fw_cmd_decoder.sv - decodes host command words into config registers, array strobes,
// execute pulses and sticky status; returns read data on the response channel
module fw_cmd_decoder
  import fw_cmd_decoder_pkg::*;
#(
  parameter logic [3:0] FW_ID      = 4'h1,
  parameter int         CFG_WORDS  = cfg_array_words,
  parameter int         DATA_WORDS = data_array_words,
  parameter int         TNUM_LSB   = 14
) (
  input  logic               fw_axi_clk,
  input  logic               fw_rst,
  fw_cmd_decoder_if.slave    host,
  output logic [23:0]        cfg_static_0,
  output logic [23:0]        cfg_static_1,
  output logic [23:0]        exec_cfg,
  output logic               exec_start,
  output logic               fw_soft_rst,
  input  logic [3:0]         test_done,
  output logic               arr_wr_en,
  output logic [2:0]         arr_sel,
  output logic [7:0]         arr_addr,
  output logic [23:0]        arr_wdata,
  output logic               arr_rd_en,
  input  logic [23:0]        arr_rdata,
  output logic [31:0]        status
);
  state_t_fw_cmd_decoder state_q, state_d;
  dec_regs_t             r_q, r_d;

  logic [3:0]  dev_id;
  op_code_t    op;
  logic [23:0] body;
  logic        hit;
  logic        ptr_inc, ptr_clear;
  logic [2:0]  ptr_sel;
  logic [7:0]  ptr_cur;

  assign dev_id = host.cmd_word[windex_device_id +: 4];
  assign op     = op_code_t'(host.cmd_word[windex_op_code +: 4]);
  assign body   = host.cmd_word[windex_body +: 24];
  assign hit    = host.cmd_valid && host.cmd_ready && (dev_id == FW_ID) && (op != OP_NOOP);

  // Writes bump the pointer on acceptance; reads bump it while arr_rd_en is high.
  assign ptr_sel   = (state_q == RD_REQ) ? r_q.arr_sel : arr_index(op);
  assign ptr_inc   = (state_q == RD_REQ) || (hit && is_wr_array(op));
  assign ptr_clear = hit && (op == OP_W_RST_FW);

  fw_cmd_array_ptr #(
    .CFG_WORDS  (CFG_WORDS),
    .DATA_WORDS (DATA_WORDS)
  ) u_ptr (
    .clk   (fw_axi_clk),
    .rst   (fw_rst),
    .clear (ptr_clear),
    .inc   (ptr_inc),
    .sel   (ptr_sel),
    .ptr   (ptr_cur)
  );

  always_ff @(posedge fw_axi_clk) begin
    if (fw_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (hit && (op == OP_R_CFG_STATIC_0 || op == OP_R_CFG_STATIC_1)) state_d = RSP;
        else if (hit && is_rd_array(op))                                 state_d = RD_REQ;
      end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: state_d = RSP;
      RSP:     if (host.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    host.cmd_ready = (state_q == IDLE) && !fw_rst;
    host.rsp_valid = (state_q == RSP);
    arr_rd_en      = (state_q == RD_REQ);
  end

  always_comb begin
    r_d             = r_q;
    r_d.exec_start  = 1'b0;
    r_d.fw_soft_rst = 1'b0;
    r_d.arr_wr_en   = 1'b0;
    if (hit) begin
      r_d.status = r_q.status | status_set_mask(op);
      if (is_wr_array(op) || is_rd_array(op)) begin
        r_d.arr_sel  = arr_index(op);
        r_d.arr_addr = ptr_cur;
      end
      case (op)
        OP_W_RST_FW: begin
          r_d.fw_soft_rst                 = 1'b1;
          r_d.cfg_static_0                = '0;
          r_d.cfg_static_1                = '0;
          r_d.exec_cfg                    = '0;
          r_d.status                      = '0;
          r_d.status[status_index_rst_fw] = 1'b1;
        end
        OP_W_CFG_STATIC_0:    r_d.cfg_static_0 = body;
        OP_W_CFG_STATIC_1:    r_d.cfg_static_1 = body;
        OP_R_CFG_STATIC_0:    r_d.rsp_word = pack_rsp(FW_ID, op, r_q.cfg_static_0);
        OP_R_CFG_STATIC_1:    r_d.rsp_word = pack_rsp(FW_ID, op, r_q.cfg_static_1);
        OP_W_STATUS_FW_CLEAR: r_d.status = '0;
        OP_W_EXECUTE: begin
          if (onehot4(body[TNUM_LSB +: 4])) begin
            r_d.exec_cfg   = body;
            r_d.exec_start = 1'b1;
          end else begin
            r_d.status[status_index_exec_err] = 1'b1;
          end
        end
        default: begin
          if (is_wr_array(op)) begin
            r_d.arr_wr_en = 1'b1;
            r_d.arr_wdata = body;
          end else if (is_rd_array(op)) begin
            r_d.rsp_word = pack_rsp(FW_ID, op, 24'h0);
          end
        end
      endcase
    end
    if (state_q == RD_WAIT) r_d.rsp_word[rindex_data +: 24] = arr_rdata;
    // test_done is OR-ed in last so it survives a same-cycle clear or soft reset.
    r_d.status[status_index_test_done +: 4] = r_d.status[status_index_test_done +: 4] | test_done;
  end

  always_ff @(posedge fw_axi_clk) begin
    if (fw_rst) r_q <= '0;
    else        r_q <= r_d;
  end

  assign host.rsp_word = r_q.rsp_word;
  assign cfg_static_0  = r_q.cfg_static_0;
  assign cfg_static_1  = r_q.cfg_static_1;
  assign exec_cfg      = r_q.exec_cfg;
  assign exec_start    = r_q.exec_start;
  assign fw_soft_rst   = r_q.fw_soft_rst;
  assign arr_wr_en     = r_q.arr_wr_en;
  assign arr_sel       = r_q.arr_sel;
  assign arr_addr      = r_q.arr_addr;
  assign arr_wdata     = r_q.arr_wdata;
  assign status        = r_q.status;

endmodule

// File: tb/tb_fw_cmd_decoder.sv
// tb/tb_fw_cmd_decoder.sv - directed table-driven bench for fw_cmd_decoder
module tb_fw_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] cfg_static_0, cfg_static_1, exec_cfg, arr_wdata, arr_rdata;
  logic        exec_start, fw_soft_rst, arr_wr_en, arr_rd_en;
  logic [3:0]  test_done;
  logic [2:0]  arr_sel;
  logic [7:0]  arr_addr;
  logic [31:0] status;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fw_cmd_decoder_if bus ();

  fw_cmd_decoder #(
    .FW_ID      (4'h1),
    .CFG_WORDS  (217),
    .DATA_WORDS (32),
    .TNUM_LSB   (14)
  ) dut (
    .fw_axi_clk   (clk),
    .fw_rst       (rst),
    .host         (bus),
    .cfg_static_0 (cfg_static_0),
    .cfg_static_1 (cfg_static_1),
    .exec_cfg     (exec_cfg),
    .exec_start   (exec_start),
    .fw_soft_rst  (fw_soft_rst),
    .test_done    (test_done),
    .arr_wr_en    (arr_wr_en),
    .arr_sel      (arr_sel),
    .arr_addr     (arr_addr),
    .arr_wdata    (arr_wdata),
    .arr_rd_en    (arr_rd_en),
    .arr_rdata    (arr_rdata),
    .status       (status)
  );

  typedef struct {
    logic [31:0] word;
    logic [23:0] cs0;
    logic [23:0] cs1;
    logic [23:0] ecfg;
    logic        es;
    logic        srst;
    logic [31:0] st;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send(input logic [31:0] w, input logic [3:0] td);
    int n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", 32'(bus.cmd_ready), 32'h1);
    bus.cmd_valid = 1'b1;
    bus.cmd_word  = w;
    test_done     = td;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_word  = '0;
    test_done     = '0;
    @(negedge clk);
  endtask

  // Ends at the negedge of the first RSP cycle; arr_rdata is only correct in RD_WAIT.
  task automatic array_read(input logic [31:0] w, input logic [2:0] exp_sel,
                            input logic [7:0] exp_addr, input logic [23:0] rd);
    logic [31:0] exp_rsp;
    exp_rsp = {4'h1, w[27:24], rd};
    send(w, 4'h0);
    check("rd_en_req", 32'(arr_rd_en), 32'h1);
    check("rd_sel", 32'(arr_sel), 32'(exp_sel));
    check("rd_addr", 32'(arr_addr), 32'(exp_addr));
    check("rsp_valid_c1", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    arr_rdata = rd;
    @(negedge clk);
    check("rd_en_wait", 32'(arr_rd_en), 32'h0);
    check("rsp_valid_c2", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    arr_rdata = 24'h111111;
    @(negedge clk);
    check("rsp_valid_c3", 32'(bus.rsp_valid), 32'h1);
    check("rsp_word_arr", bus.rsp_word, exp_rsp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h12ABCDEF, 24'hABCDEF, 24'h000000, 24'h000000, 1'b0, 1'b0, 32'h0000_0002};
    vecs[1] = '{32'h14123456, 24'hABCDEF, 24'h123456, 24'h000000, 1'b0, 1'b0, 32'h0000_000A};
    vecs[2] = '{32'h2F004000, 24'hABCDEF, 24'h123456, 24'h000000, 1'b0, 1'b0, 32'h0000_000A};
    vecs[3] = '{32'h1F00C000, 24'hABCDEF, 24'h123456, 24'h000000, 1'b0, 1'b0, 32'h8000_200A};
    vecs[4] = '{32'h1F008000, 24'hABCDEF, 24'h123456, 24'h008000, 1'b1, 1'b0, 32'h8000_200A};
    vecs[5] = '{32'h10000000, 24'hABCDEF, 24'h123456, 24'h008000, 1'b0, 1'b0, 32'h8000_200A};
    vecs[6] = '{32'h1E000000, 24'hABCDEF, 24'h123456, 24'h008000, 1'b0, 1'b0, 32'h0000_0000};
    vecs[7] = '{32'h11000000, 24'h000000, 24'h000000, 24'h000000, 1'b0, 1'b1, 32'h0000_0001};
    vecs[8] = '{32'h12000055, 24'h000055, 24'h000000, 24'h000000, 1'b0, 1'b0, 32'h0000_0003};

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_word  = '0;
    bus.rsp_ready = 1'b0;
    test_done     = '0;
    arr_rdata     = 24'h111111;
    repeat (3) @(negedge clk);
    check("cmd_ready_in_reset", 32'(bus.cmd_ready), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_status", status, 32'h0);
    check("reset_cfg0", 32'(cfg_static_0), 32'h0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("reset_wr_en", 32'(arr_wr_en), 32'h0);
    check("reset_rd_en", 32'(arr_rd_en), 32'h0);
    check("reset_addr", 32'(arr_addr), 32'h0);
    check("reset_cmd_ready", 32'(bus.cmd_ready), 32'h1);

    for (int v = 0; v < 9; v++) begin
      send(vecs[v].word, 4'h0);
      check($sformatf("v%0d_cfg0", v), 32'(cfg_static_0), 32'(vecs[v].cs0));
      check($sformatf("v%0d_cfg1", v), 32'(cfg_static_1), 32'(vecs[v].cs1));
      check($sformatf("v%0d_exec_cfg", v), 32'(exec_cfg), 32'(vecs[v].ecfg));
      check($sformatf("v%0d_exec_start", v), 32'(exec_start), 32'(vecs[v].es));
      check($sformatf("v%0d_soft_rst", v), 32'(fw_soft_rst), 32'(vecs[v].srst));
      check($sformatf("v%0d_status", v), status, vecs[v].st);
      check($sformatf("v%0d_cmd_ready", v), 32'(bus.cmd_ready), 32'h1);
    end

    // static register read-back
    send(32'h12ABCDEF, 4'h0);
    send(32'h13000000, 4'h0);
    check("static_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("static_rsp_word", bus.rsp_word, 32'h13ABCDEF);
    check("static_cmd_ready", 32'(bus.cmd_ready), 32'h0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("static_rsp_done", 32'(bus.rsp_valid), 32'h0);
    check("static_idle", 32'(bus.cmd_ready), 32'h1);
    check("static_status", status, 32'h0000_0007);

    // cfg_array_0 write stream across the wrap point
    for (int i = 0; i < 218; i++) begin
      send(32'h16000000 | 32'(i), 4'h0);
      check($sformatf("wr%0d_en", i), 32'(arr_wr_en), 32'h1);
      check($sformatf("wr%0d_addr", i), 32'(arr_addr), 32'(i % 217));
      check($sformatf("wr%0d_data", i), 32'(arr_wdata), 32'(i));
      check($sformatf("wr%0d_sel", i), 32'(arr_sel), 32'h0);
    end
    @(negedge clk);
    check("wr_en_drop", 32'(arr_wr_en), 32'h0);

    array_read(32'h17000000, 3'd0, 8'd1, 24'h5A5A5A);

    // response held under back-pressure, a command offered meanwhile must be ignored
    bus.cmd_valid = 1'b1;
    bus.cmd_word  = 32'h12FFFFFF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d_valid", c), 32'(bus.rsp_valid), 32'h1);
      check($sformatf("hold%0d_word", c), bus.rsp_word, 32'h175A5A5A);
      check($sformatf("hold%0d_cmd_ready", c), 32'(bus.cmd_ready), 32'h0);
    end
    check("hold_cfg0", 32'(cfg_static_0), 32'hABCDEF);
    bus.cmd_valid = 1'b0;
    bus.cmd_word  = '0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'h0);
    check("midrst_cfg0", 32'(cfg_static_0), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_idle", 32'(bus.cmd_ready), 32'h1);
    check("postrst_status", status, 32'h0);

    // data array reads with same-cycle response acceptance
    bus.rsp_ready = 1'b1;
    array_read(32'h1C000000, 3'd3, 8'd0, 24'hC0FFEE);
    array_read(32'h1C000000, 3'd3, 8'd1, 24'h123ABC);
    array_read(32'h1D000000, 3'd4, 8'd0, 24'h00BEEF);
    @(negedge clk);
    check("data_rsp_done", 32'(bus.rsp_valid), 32'h0);
    bus.rsp_ready = 1'b0;
    check("data_status", status, 32'h0000_1800);

    // clear racing test_done, then test_done alone
    send(32'h12000001, 4'h0);
    check("pre_clear_status", status, 32'h0000_1802);
    send(32'h1E000000, 4'b0001);
    check("clear_vs_done", status, 32'h0000_4000);
    test_done = 4'b1010;
    @(posedge clk);
    #1;
    test_done = 4'b0000;
    @(negedge clk);
    check("test_done_sticky", status, 32'h0002_C000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
